// File: rtl/rom_scan_ctrl.sv
// Address sequencer for the LED pattern ROM: timed up/down scan (one-shot or looping),
// manual single-step in IDLE, and a registered copy of the ROM output on the LED bus.
module rom_scan_ctrl #(
   parameter int TICK_DIV = 100_000_000,
   parameter int ADDR_W   = 3,
   parameter int DATA_W   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   input  logic              step,
   input  logic              dir,
   input  logic              loop_en,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic [DATA_W-1:0] led,
   output logic              busy,
   output logic              done
);

   localparam int CNT_W = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t              state_reg, state_next;
   logic [ADDR_W-1:0]   addr_reg, addr_next;
   logic [CNT_W-1:0]    cnt_reg, cnt_next;
   logic [DATA_W-1:0]   led_reg;
   logic                busy_reg, busy_next;
   logic                done_reg, done_next;
   logic                cap_reg;

   logic                tick;
   logic                at_end;
   logic [ADDR_W-1:0]   first_addr;
   logic [ADDR_W-1:0]   addr_adv;

   assign tick       = (state_reg == RUN) && (cnt_reg == CNT_LAST);
   assign at_end     = dir ? (addr_reg == '0) : (addr_reg == ADDR_MAX);
   assign first_addr = dir ? ADDR_MAX : '0;
   assign addr_adv   = dir ? (addr_reg - ADDR_ONE) : (addr_reg + ADDR_ONE);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic; stop outranks start, which outranks the end-of-scan tick
   always_comb begin
      state_next = state_reg;
      if (stop) begin
         state_next = IDLE;
      end else if (start) begin
         state_next = RUN;
      end else if (tick && at_end && !loop_en) begin
         state_next = IDLE;
      end
   end

   // Output / datapath next values
   always_comb begin
      addr_next = addr_reg;
      cnt_next  = '0;
      done_next = 1'b0;
      if (stop) begin
         addr_next = addr_reg;
      end else if (start) begin
         addr_next = first_addr;
      end else if (state_reg == RUN) begin
         if (tick) begin
            if (!at_end) begin
               addr_next = addr_adv;
            end else if (loop_en) begin
               addr_next = first_addr;
            end else begin
               done_next = 1'b1;
            end
         end else begin
            cnt_next = cnt_reg + CNT_ONE;
         end
      end else if (step) begin
         addr_next = addr_adv;
      end
      busy_next = (state_next == RUN);
   end

   // cap starts at 1 so the first edge after reset loads rom[0] onto the LEDs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_reg <= '0;
         cnt_reg  <= '0;
         led_reg  <= '0;
         busy_reg <= 1'b0;
         done_reg <= 1'b0;
         cap_reg  <= 1'b1;
      end else begin
         addr_reg <= addr_next;
         cnt_reg  <= cnt_next;
         busy_reg <= busy_next;
         done_reg <= done_next;
         cap_reg  <= (addr_next != addr_reg);
         if (cap_reg) begin
            led_reg <= rom_data;
         end
      end
   end

   assign rom_addr = addr_reg;
   assign led      = led_reg;
   assign busy     = busy_reg;
   assign done     = done_reg;

endmodule

// File: tb/tb_rom_scan_ctrl.sv
// Directed bench for rom_scan_ctrl with TICK_DIV=4 and a ROM returning 8'h10 + addr.
module tb_rom_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0, stop = 1'b0, step = 1'b0, dir = 1'b0, loop_en = 1'b0;
   logic [2:0] rom_addr;
   logic [7:0] rom_data;
   logic [7:0] led;
   logic       busy, done;

   int checks = 0;
   int failures = 0;

   rom_scan_ctrl #(.TICK_DIV(4), .ADDR_W(3), .DATA_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .step(step),
      .dir(dir), .loop_en(loop_en), .rom_addr(rom_addr), .rom_data(rom_data),
      .led(led), .busy(busy), .done(done)
   );

   assign rom_data = 8'h10 + {5'b00000, rom_addr};

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      // 1: reset and idle
      cyc(2);
      chk("rst_addr", rom_addr, 0);
      chk("rst_led", led, 8'h00);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      rst = 1'b0;
      cyc(1);
      chk("first_led", led, 8'h10);
      cyc(3);
      chk("idle_addr", rom_addr, 0);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      $display("step1 reset/idle done");

      // 2: one-shot ascending
      dir = 1'b0; loop_en = 1'b0; start = 1'b1;
      cyc(1);
      start = 1'b0;
      chk("up_start_addr", rom_addr, 0);
      chk("up_start_busy", busy, 1);
      for (int k = 1; k < 8; k++) begin
         cyc(1);
         chk("up_led", led, 8'h10 + k - 1);
         cyc(2);
         chk("up_hold", rom_addr, k - 1);
         cyc(1);
         chk("up_adv", rom_addr, k);
         chk("up_nodone", done, 0);
      end
      cyc(1);
      chk("up_led7", led, 8'h17);
      cyc(2);
      chk("up_pre_end_busy", busy, 1);
      chk("up_pre_end_done", done, 0);
      cyc(1);
      chk("up_end_done", done, 1);
      chk("up_end_busy", busy, 0);
      chk("up_end_addr", rom_addr, 7);
      cyc(1);
      chk("up_done_once", done, 0);
      chk("up_addr_held", rom_addr, 7);
      $display("step2 one-shot ascending done");

      // 3: looping descending, then stop
      dir = 1'b1; loop_en = 1'b1; start = 1'b1;
      cyc(1);
      start = 1'b0;
      chk("dn_start_addr", rom_addr, 7);
      chk("dn_start_busy", busy, 1);
      for (int i = 1; i <= 9; i++) begin
         for (int j = 0; j < 4; j++) begin
            cyc(1);
            chk("dn_nodone", done, 0);
         end
         chk("dn_addr", rom_addr, (7 - i) & 7);
         chk("dn_busy", busy, 1);
      end
      stop = 1'b1;
      cyc(1);
      stop = 1'b0;
      chk("stop_busy", busy, 0);
      chk("stop_addr", rom_addr, 6);
      chk("stop_led", led, 8'h16);
      for (int i = 0; i < 12; i++) begin
         cyc(1);
         chk("stop_hold_addr", rom_addr, 6);
         chk("stop_hold_done", done, 0);
      end
      $display("step3 looping descending + stop done");

      // 4: manual step
      dir = 1'b0; step = 1'b1;
      cyc(1);
      step = 1'b0;
      chk("step_to7", rom_addr, 7);
      step = 1'b1;
      cyc(1);
      step = 1'b0;
      chk("step_wrap_up", rom_addr, 0);
      cyc(1);
      chk("step_led10", led, 8'h10);
      dir = 1'b1; step = 1'b1;
      cyc(1);
      step = 1'b0;
      chk("step_wrap_dn", rom_addr, 7);
      cyc(1);
      chk("step_led17", led, 8'h17);
      dir = 1'b0; loop_en = 1'b1; start = 1'b1;
      cyc(1);
      start = 1'b0;
      chk("run_start_addr", rom_addr, 0);
      step = 1'b1;
      cyc(1);
      step = 1'b0;
      chk("run_step_ignored", rom_addr, 0);
      cyc(2);
      chk("run_pre_tick", rom_addr, 0);
      cyc(1);
      chk("run_tick", rom_addr, 1);
      $display("step4 manual step done");

      // 5: command priorities
      cyc(3);
      stop = 1'b1;
      cyc(1);
      stop = 1'b0;
      chk("stop_tick_addr", rom_addr, 1);
      chk("stop_tick_busy", busy, 0);
      chk("stop_tick_done", done, 0);
      start = 1'b1; stop = 1'b1;
      cyc(1);
      start = 1'b0; stop = 1'b0;
      chk("startstop_busy", busy, 0);
      chk("startstop_addr", rom_addr, 1);
      cyc(4);
      chk("startstop_hold", rom_addr, 1);
      chk("startstop_idle", busy, 0);
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      chk("re_start_addr", rom_addr, 0);
      cyc(20);
      chk("re_at5", rom_addr, 5);
      cyc(2);
      chk("re_mid5", rom_addr, 5);
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      chk("re_reload", rom_addr, 0);
      chk("re_busy", busy, 1);
      cyc(3);
      chk("re_pre_adv", rom_addr, 0);
      cyc(1);
      chk("re_adv", rom_addr, 1);
      $display("step5 priorities done");

      // 6: reset mid-scan
      cyc(8);
      chk("mid_addr3", rom_addr, 3);
      cyc(1);
      chk("mid_led13", led, 8'h13);
      cyc(1);
      rst = 1'b1;
      #2;
      chk("arst_addr", rom_addr, 0);
      chk("arst_busy", busy, 0);
      chk("arst_led", led, 8'h00);
      chk("arst_done", done, 0);
      #2;
      rst = 1'b0;
      cyc(1);
      chk("rel_led", led, 8'h10);
      chk("rel_addr", rom_addr, 0);
      chk("rel_done", done, 0);
      cyc(8);
      chk("rel_idle_addr", rom_addr, 0);
      chk("rel_idle_busy", busy, 0);
      $display("step6 reset mid-scan done");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rom_scan_ctrl.md
# rom_scan_ctrl

Sequencer for the 8-entry pattern ROM that drives the board LEDs. Instead of taking the ROM address straight from switches, it steps the address automatically at a programmable rate, either up or down, in one-shot or looping mode, and supports manual single-step. It registers the ROM output so the LED bus changes cleanly. It sits between the user-input conditioning logic (debounced, single-cycle pulses) and the combinational `rom_module`.

## Interface

- TICK_DIV, 100_000_000: clock cycles per automatic step; legal range ≥ 2. The counter width is $clog2(TICK_DIV).
- ADDR_W, 3: ROM address width; the sequence covers 0 .. 2^ADDR_W−1.
- DATA_W, 8: ROM data / LED width.

- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse: begin an automatic scan.
- stop  in  1  single-cycle pulse: abort the scan and hold the current address.
- step  in  1  single-cycle pulse: advance one address (only acted on in IDLE).
- dir  in  1  0 = ascending, 1 = descending.
- loop_en  in  1  1 = wrap and continue at the end of the sequence; 0 = finish.
- rom_addr  out  ADDR_W  registered address to `rom_module`.
- rom_data  in  DATA_W  combinational ROM output.
- led  out  DATA_W  registered copy of rom_data.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when a one-shot scan completes.

## Operation

- States: IDLE, RUN.
- Priority of commands in the same cycle: stop > start > tick > step.
- **IDLE**
  - start: rom_addr loads the first address (0 if dir=0, 2^ADDR_W−1 if dir=1), the prescaler clears, and the state goes to RUN.
  - step: rom_addr advances by ±1 per dir, always wrapping modulo 2^ADDR_W; loop_en is ignored.
- **RUN**
  - The prescaler counts 0 .. TICK_DIV−1. The tick is the cycle where count = TICK_DIV−1; the counter then returns to 0.
  - On a tick, if rom_addr is not the end address for the current dir, it moves by ±1.
  - At the end address (2^ADDR_W−1 ascending, 0 descending):
    - loop_en=1: wrap to the opposite end and stay in RUN.
    - loop_en=0: rom_addr holds, done pulses, and the state goes to IDLE.
  - dir and loop_en are sampled live at each tick.
  - step is ignored.
  - start restarts from the first address and clears the prescaler.
  - stop: go to IDLE, hold rom_addr, clear the prescaler, no done pulse.
- **LED capture:** an internal cap flag is set on every rom_addr change. On the following edge, led ← rom_data and cap clears. The cap flag resets to 1 so that rom[0] is shown right after reset.
- The prescaler is held at 0 in IDLE.
- busy = (state == RUN), registered.

## Timing

- Reset values, applied asynchronously: state IDLE, rom_addr 0, led 0, busy 0, done 0, prescaler 0, cap 1.
- First edge after rst deasserts: led = rom[0].
- Command latency: start/step/stop sampled at edge N → rom_addr/busy valid after edge N. led follows at edge N+1.
- In RUN, consecutive address changes are exactly TICK_DIV cycles apart. The first advance after start occurs TICK_DIV cycles after the start edge.
- A one-shot ascending scan gives 8 addresses in total. done is high for exactly one cycle, in the same cycle that busy falls, which is the tick at address 7.
- Reset mid-scan: all outputs return to their reset values immediately, with no done pulse.
- stop in the same cycle as a tick: no advance and no done pulse.

## Test plan

Bench setup for all scenarios: TICK_DIV=4, and a ROM model returning rom_data = 8'h10 + addr.

1. Reset, then idle 3 cycles → rom_addr=0, busy=0, done=0, and led=8'h10 from the first edge after release.
2. start, dir=0, loop_en=0 → rom_addr 0,1,…,7 at 4-cycle spacing, with led lagging one cycle each time (8'h10…8'h17). At the tick on address 7: done pulses for 1 cycle, busy falls, rom_addr stays 7.
3. start, dir=1, loop_en=1 → sequence 7,6,…,0,7,6 with no done pulse. Then stop → busy=0, rom_addr held, and no change for ≥ 10 cycles.
4. In IDLE at addr 7: step with dir=0 → addr 0, led=8'h10. Then step with dir=1 → addr 7, led=8'h17. Then step in RUN → no effect.
5. Same-cycle start+stop in IDLE → remains IDLE. stop coincident with a tick in RUN → address unchanged, no done. start during RUN at addr 5 → addr reloads 0 and the next advance comes 4 cycles later.
6. Assert rst at addr 3 in RUN, mid-count → immediately rom_addr=0, busy=0, led=0. After release, led=8'h10 on the first edge.
